// File: rtl/jtag_dr_tx.sv
// JTAG data-register transmit path for ER1/ER2. Oversamples jtck in the clk48m domain,
// captures a per-chain holding word at Capture-DR and shifts it out LSB first.
`timescale 1ns/1ps
module jtag_dr_tx #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jtck,
    input  logic             jshift,
    input  logic             jce1,
    input  logic             jce2,
    input  logic             jrstn,
    output logic             jtdo1,
    output logic             jtdo2,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_we,
    input  logic             tx_sel,
    output logic [1:0]       tx_pending,
    output logic             tx_taken,
    output logic             tx_taken_sel
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [3:0]       ts;
    logic [0:0]       state;
    logic             cur;
    logic [WIDTH-1:0] sr;
    logic             tdo;
    logic [1:0]       pending;
    logic [1:0]       pending_nxt;
    logic [WIDTH-1:0] hold [2];

    logic rise;
    logic fall;
    logic jce_any;
    logic capture;
    logic shift_en;
    logic exit_en;
    logic cap_sel;

    assign rise     = !ts[3] &&  ts[2];
    assign fall     =  ts[3] && !ts[2];
    assign jce_any  = jce1 || jce2;
    assign cap_sel  = jce2;
    // A TAP reset overrides any edge seen in the same cycle.
    assign capture  = jrstn && rise && jce_any && !jshift;
    assign shift_en = (state == ST_SHIFT) && rise && jshift && jce_any;
    assign exit_en  = (state == ST_SHIFT) && rise && !jshift && !jce1 && !jce2;

    // Capture consumes the old flag; a same-cycle write to that chain re-arms it.
    always_comb begin
        pending_nxt = pending;
        if (capture) pending_nxt[cap_sel] = 1'b0;
        if (tx_we)   pending_nxt[tx_sel]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts           <= '0;
            state        <= ST_IDLE;
            cur          <= 1'b0;
            sr           <= '0;
            tdo          <= 1'b0;
            pending      <= '0;
            hold[0]      <= '0;
            hold[1]      <= '0;
            tx_taken     <= 1'b0;
            tx_taken_sel <= 1'b0;
        end else begin
            tx_taken <= 1'b0;
            pending  <= pending_nxt;
            if (tx_we) hold[tx_sel] <= tx_data;
            if (capture) begin
                cur          <= cap_sel;
                tx_taken     <= pending[cap_sel];
                tx_taken_sel <= cap_sel;
            end
            // TAP reset clears the scan path but keeps holding words and flags.
            if (!jrstn) begin
                ts    <= '0;
                state <= ST_IDLE;
                sr    <= '0;
                tdo   <= 1'b0;
            end else begin
                ts <= {ts[2:0], jtck};
                if (capture) begin
                    state <= ST_SHIFT;
                    sr    <= pending[cap_sel] ? hold[cap_sel] : '0;
                end else if (shift_en) begin
                    sr <= {1'b0, sr[WIDTH-1:1]};
                end else if (exit_en) begin
                    state <= ST_IDLE;
                end
                if (fall) tdo <= sr[0];
            end
        end
    end

    assign jtdo1      = tdo & !cur;
    assign jtdo2      = tdo &  cur;
    assign tx_pending = pending;

endmodule

// File: tb/tb_jtag_dr_tx.sv
// Self-checking bench for jtag_dr_tx: table of DR scans plus hand-written corner sequences,
// with host-side TDO samples checked against a queue of expected bits.
`timescale 1ns/1ps
module tb_jtag_dr_tx;

    localparam int WIDTH = 32;
    localparam int HALF  = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             jtck;
    logic             jshift;
    logic             jce1;
    logic             jce2;
    logic             jrstn;
    logic             jtdo1;
    logic             jtdo2;
    logic [WIDTH-1:0] tx_data;
    logic             tx_we;
    logic             tx_sel;
    logic [1:0]       tx_pending;
    logic             tx_taken;
    logic             tx_taken_sel;

    always #5 clk = ~clk;

    jtag_dr_tx #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .jtck(jtck), .jshift(jshift), .jce1(jce1), .jce2(jce2),
        .jrstn(jrstn), .jtdo1(jtdo1), .jtdo2(jtdo2), .tx_data(tx_data), .tx_we(tx_we),
        .tx_sel(tx_sel), .tx_pending(tx_pending), .tx_taken(tx_taken),
        .tx_taken_sel(tx_taken_sel)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   taken_cnt = 0;
    logic taken_sel_last = 1'b0;
    bit   sb [$];

    typedef struct {
        bit          wr;
        bit          wsel;
        logic [31:0] wdata;
        bit          chain;
        int          nbits;
        logic [31:0] exp_word;
        int          exp_taken;
        logic [1:0]  exp_pend;
    } vec_t;

    vec_t vecs [5];

    always @(negedge clk) begin
        if (tx_taken) begin
            taken_cnt++;
            taken_sel_last = tx_taken_sel;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic clkn(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input bit sel, input logic [31:0] d);
        tx_data = d;
        tx_sel  = sel;
        tx_we   = 1'b1;
        clkn(1);
        tx_we = 1'b0;
        check("pending_set", {31'd0, tx_pending[sel]}, 32'd1);
    endtask

    // One TCK period; TAP signals change while TCK is low, host samples TDO at the rise.
    task automatic tck(input logic sh, input logic c1, input logic c2, input bit smp, input bit ch);
        bit e;
        jshift = sh;
        jce1   = c1;
        jce2   = c2;
        clkn(HALF);
        jtck = 1'b1;
        if (smp) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
                e = 1'b0;
            end else begin
                e = sb.pop_front();
            end
            check(ch ? "jtdo2_bit" : "jtdo1_bit", {31'd0, ch ? jtdo2 : jtdo1}, {31'd0, e});
            check(ch ? "jtdo1_quiet" : "jtdo2_quiet", {31'd0, ch ? jtdo1 : jtdo2}, 32'd0);
        end
        clkn(HALF);
        jtck = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w, input int nbits);
        for (int k = 0; k < nbits; k++) sb.push_back(k < 32 ? w[k] : 1'b0);
    endtask

    task automatic scan(input bit ch, input int nbits, input logic [31:0] w, input bit do_exit);
        push_word(w, nbits);
        tck(1'b0, !ch, ch, 1'b0, ch);
        for (int k = 0; k < nbits; k++) tck(1'b1, !ch, ch, 1'b1, ch);
        if (do_exit) tck(1'b0, 1'b0, 1'b0, 1'b0, ch);
    endtask

    initial begin
        int t0;
        rst = 1'b1; jtck = 1'b0; jshift = 1'b0; jce1 = 1'b0; jce2 = 1'b0; jrstn = 1'b1;
        tx_data = '0; tx_we = 1'b0; tx_sel = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32, 32'hDEADBEEF, 1, 2'b00};
        vecs[1] = '{1'b0, 1'b0, 32'h0,        1'b1, 32, 32'h0,        0, 2'b00};
        vecs[2] = '{1'b1, 1'b1, 32'h00000001, 1'b1, 40, 32'h00000001, 1, 2'b00};
        vecs[3] = '{1'b1, 1'b1, 32'h12345678, 1'b0, 32, 32'h0,        0, 2'b10};
        vecs[4] = '{1'b0, 1'b0, 32'h0,        1'b1, 32, 32'h12345678, 1, 2'b00};

        clkn(3);
        check("rst_jtdo1", {31'd0, jtdo1}, 32'd0);
        check("rst_jtdo2", {31'd0, jtdo2}, 32'd0);
        check("rst_pending", {30'd0, tx_pending}, 32'd0);
        check("rst_taken", {31'd0, tx_taken}, 32'd0);
        check("rst_taken_sel", {31'd0, tx_taken_sel}, 32'd0);
        rst = 1'b0;
        clkn(2);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].wr) wr(vecs[i].wsel, vecs[i].wdata);
            t0 = taken_cnt;
            scan(vecs[i].chain, vecs[i].nbits, vecs[i].exp_word, 1'b1);
            clkn(4);
            check("vec_taken_cnt", taken_cnt - t0, vecs[i].exp_taken);
            if (vecs[i].exp_taken != 0)
                check("vec_taken_sel", {31'd0, taken_sel_last}, {31'd0, vecs[i].chain});
            check("vec_pending", {30'd0, tx_pending}, {30'd0, vecs[i].exp_pend});
        end

        // Write to ER1 landing in the same clk cycle as the capture rise.
        wr(1'b0, 32'h11111111);
        jshift = 1'b0; jce1 = 1'b1; jce2 = 1'b0;
        clkn(HALF);
        push_word(32'h11111111, 32);
        jtck = 1'b1;
        clkn(3);
        tx_data = 32'h22222222; tx_sel = 1'b0; tx_we = 1'b1;
        clkn(1);
        tx_we = 1'b0;
        check("sim_taken", {31'd0, tx_taken}, 32'd1);
        check("sim_taken_sel", {31'd0, tx_taken_sel}, 32'd0);
        check("sim_pending", {30'd0, tx_pending}, 32'd1);
        clkn(1);
        check("sim_taken_off", {31'd0, tx_taken}, 32'd0);
        clkn(HALF - 5);
        jtck = 1'b0;
        for (int k = 0; k < 32; k++) tck(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tck(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sim_pending_after", {30'd0, tx_pending}, 32'd1);
        scan(1'b0, 32, 32'h22222222, 1'b1);
        clkn(2);
        check("sim_pending_final", {30'd0, tx_pending}, 32'd0);

        // TAP reset in the middle of a scan.
        wr(1'b0, 32'hA5A5A5A5);
        wr(1'b1, 32'hCAFEF00D);
        scan(1'b0, 10, 32'hA5A5A5A5, 1'b0);
        jshift = 1'b0; jce1 = 1'b0; jce2 = 1'b0;
        clkn(4);
        check("tap_pre_jtdo1", {31'd0, jtdo1}, 32'd1);
        jrstn = 1'b0;
        clkn(1);
        check("tap_jtdo1", {31'd0, jtdo1}, 32'd0);
        clkn(5);
        check("tap_jtdo1_hold", {31'd0, jtdo1}, 32'd0);
        check("tap_jtdo2_hold", {31'd0, jtdo2}, 32'd0);
        check("tap_pending_kept", {30'd0, tx_pending}, 32'd2);
        jrstn = 1'b1;
        clkn(4);
        wr(1'b0, 32'h0000FFFF);
        scan(1'b0, 32, 32'h0000FFFF, 1'b1);
        scan(1'b1, 32, 32'hCAFEF00D, 1'b1);
        clkn(2);
        check("tap_pending_final", {30'd0, tx_pending}, 32'd0);

        // System reset during Shift-DR.
        wr(1'b1, 32'hFFFFFFFF);
        wr(1'b0, 32'h12345678);
        scan(1'b1, 5, 32'hFFFFFFFF, 1'b0);
        clkn(2);
        check("srst_pre_jtdo2", {31'd0, jtdo2}, 32'd1);
        rst = 1'b1;
        clkn(1);
        check("srst_jtdo1", {31'd0, jtdo1}, 32'd0);
        check("srst_jtdo2", {31'd0, jtdo2}, 32'd0);
        check("srst_pending", {30'd0, tx_pending}, 32'd0);
        check("srst_taken", {31'd0, tx_taken}, 32'd0);
        check("srst_taken_sel", {31'd0, tx_taken_sel}, 32'd0);
        rst = 1'b0;
        jshift = 1'b0; jce1 = 1'b0; jce2 = 1'b0;
        clkn(3);
        t0 = taken_cnt;
        scan(1'b0, 32, 32'h0, 1'b1);
        scan(1'b1, 32, 32'h0, 1'b1);
        clkn(4);
        check("srst_no_taken", taken_cnt - t0, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
